// File: rtl/wt_buf_rd_resp.sv
// Weight-buffer read responder: owns the RAM port, DMA writes pre-empt reads, words return in order via an FWFT FIFO.
// Latency RD_LAT+1 from accept to wt_dat_vld; requests stall once in-flight plus queued words reach FIFO_DEP.
module wt_buf_rd_resp #(
    parameter int DAT_W    = 512,
    parameter int ADDR_W   = 12,
    parameter int RD_LAT   = 2,
    parameter int FIFO_DEP = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          wt_addr_vld,
    input  logic [ADDR_W-1:0]             wt_addr,
    input  logic                          wt_addr_last,
    output logic                          wt_addr_rdy,
    input  logic                          dma_wr_en,
    input  logic [ADDR_W-1:0]             dma_wr_addr,
    input  logic [DAT_W-1:0]              dma_wr_dat,
    output logic                          ram_en,
    output logic                          ram_we,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [DAT_W-1:0]              ram_wdat,
    input  logic [DAT_W-1:0]              ram_rdat,
    output logic                          wt_dat_vld,
    output logic [DAT_W-1:0]              wt_dat,
    output logic                          wt_dat_last,
    input  logic                          wt_dat_rdy,
    output logic [$clog2(FIFO_DEP):0]     outstanding,
    output logic                          idle
);
    localparam int PTR_W = $clog2(FIFO_DEP);
    localparam int CNT_W = PTR_W + 1;

    logic              accept;
    logic              pop;
    logic              push;
    logic [RD_LAT-1:0] tag_vld;
    logic [RD_LAT-1:0] tag_last;
    logic [DAT_W-1:0]  fifo_mem  [FIFO_DEP];
    logic              fifo_last [FIFO_DEP];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [CNT_W-1:0]  fifo_cnt_nxt;

    // Credit limit counts reads still in the RAM pipe, so a launched read always has a FIFO slot.
    assign wt_addr_rdy = rst_n & ~dma_wr_en & ~clear & (outstanding < CNT_W'(FIFO_DEP));
    assign accept      = wt_addr_vld & wt_addr_rdy;
    assign pop         = wt_dat_vld & wt_dat_rdy;
    assign push        = tag_vld[RD_LAT-1] & ~clear;
    assign idle        = (outstanding == '0);

    always_comb begin
        ram_en   = dma_wr_en | accept;
        ram_we   = dma_wr_en;
        ram_addr = dma_wr_en ? dma_wr_addr : wt_addr;
        ram_wdat = dma_wr_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld  <= '0;
            tag_last <= '0;
        end else if (clear) begin
            tag_vld  <= '0;
            tag_last <= '0;
        end else begin
            tag_vld[0]  <= accept;
            tag_last[0] <= wt_addr_last;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_last[i] <= tag_last[i-1];
            end
        end
    end

    always_comb begin
        fifo_cnt_nxt = fifo_cnt;
        if (push && !pop) begin
            fifo_cnt_nxt = fifo_cnt + 1'b1;
        end else if (pop && !push) begin
            fifo_cnt_nxt = fifo_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            wt_dat_vld <= 1'b0;
            for (int i = 0; i < FIFO_DEP; i++) begin
                fifo_mem[i]  <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            wt_dat_vld <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr]  <= ram_rdat;
                fifo_last[wr_ptr] <= tag_last[RD_LAT-1];
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_cnt   <= fifo_cnt_nxt;
            wt_dat_vld <= (fifo_cnt_nxt != '0);
        end
    end

    assign wt_dat      = fifo_mem[rd_ptr];
    assign wt_dat_last = fifo_last[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else if (clear) begin
            outstanding <= '0;
        end else if (accept && !pop) begin
            outstanding <= outstanding + 1'b1;
        end else if (pop && !accept) begin
            outstanding <= outstanding - 1'b1;
        end
    end
endmodule

// File: tb/tb_wt_buf_rd_resp.sv
// Directed bench for wt_buf_rd_resp with a 2-cycle RAM model and an in-order expected-word queue.
module tb_wt_buf_rd_resp;
    localparam int DAT_W  = 512;
    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic              wt_addr_vld;
    logic [ADDR_W-1:0] wt_addr;
    logic              wt_addr_last;
    logic              wt_addr_rdy;
    logic              dma_wr_en;
    logic [ADDR_W-1:0] dma_wr_addr;
    logic [DAT_W-1:0]  dma_wr_dat;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DAT_W-1:0]  ram_wdat;
    logic [DAT_W-1:0]  ram_rdat;
    logic              wt_dat_vld;
    logic [DAT_W-1:0]  wt_dat;
    logic              wt_dat_last;
    logic              wt_dat_rdy;
    logic [2:0]        outstanding;
    logic              idle;

    always #5 clk = ~clk;

    wt_buf_rd_resp #(.DAT_W(DAT_W), .ADDR_W(ADDR_W), .RD_LAT(2), .FIFO_DEP(4)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .wt_addr_vld(wt_addr_vld), .wt_addr(wt_addr), .wt_addr_last(wt_addr_last),
        .wt_addr_rdy(wt_addr_rdy),
        .dma_wr_en(dma_wr_en), .dma_wr_addr(dma_wr_addr), .dma_wr_dat(dma_wr_dat),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdat(ram_wdat),
        .ram_rdat(ram_rdat),
        .wt_dat_vld(wt_dat_vld), .wt_dat(wt_dat), .wt_dat_last(wt_dat_last),
        .wt_dat_rdy(wt_dat_rdy),
        .outstanding(outstanding), .idle(idle)
    );

    // Single-port RAM, read data two cycles after the read enable.
    logic [DAT_W-1:0] ram_mem [0:63];
    logic [DAT_W-1:0] rd1;
    always @(posedge clk) begin
        if (ram_en && ram_we) ram_mem[ram_addr[5:0]] <= ram_wdat;
        if (ram_en && !ram_we) rd1 <= ram_mem[ram_addr[5:0]];
        ram_rdat <= rd1;
    end

    typedef struct packed {
        logic [DAT_W-1:0] d;
        logic             l;
    } exp_t;

    exp_t             q[$];
    logic [DAT_W-1:0] exp_mem [0:63];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nacc  = 0;
    int npop  = 0;
    int first_acc = -1;
    int first_vld = -1;
    bit acc;

    task automatic chk(input string tag, input logic [DAT_W-1:0] got, input logic [DAT_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge with inputs set; scores this cycle and returns at the next falling edge.
    task automatic tick();
        exp_t e;
        #1;
        cyc++;
        acc = 1'b0;
        if (!rst_n) begin
            q.delete();
        end else begin
            if (dma_wr_en) exp_mem[dma_wr_addr[5:0]] = dma_wr_dat;
            if (clear) begin
                q.delete();
            end else begin
                chk("out_max", outstanding <= 3'd4, 1);
                if (wt_dat_vld && first_vld < 0) first_vld = cyc;
                if (wt_dat_vld && wt_dat_rdy) begin
                    npop++;
                    if (q.size() == 0) begin
                        chk("unexp_pop", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("dat", wt_dat, e.d);
                        chk("last", wt_dat_last, e.l);
                    end
                end
                acc = wt_addr_vld && wt_addr_rdy;
                if (acc) begin
                    nacc++;
                    if (first_acc < 0) first_acc = cyc;
                    e.d = exp_mem[wt_addr[5:0]];
                    e.l = wt_addr_last;
                    q.push_back(e);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic dwr(input int a, input logic [DAT_W-1:0] d);
        dma_wr_en = 1'b1; dma_wr_addr = ADDR_W'(a); dma_wr_dat = d;
        tick();
        dma_wr_en = 1'b0;
    endtask

    task automatic send(input int a, input bit l);
        int n = 0;
        wt_addr_vld = 1'b1; wt_addr = ADDR_W'(a); wt_addr_last = l;
        do begin
            tick();
            n++;
        end while (!acc && n < 100);
        wt_addr_vld = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        wt_addr_vld = 1'b0;
        wt_dat_rdy  = 1'b1;
        while (!(idle && !wt_dat_vld && q.size() == 0) && n < 60) begin
            tick();
            n++;
        end
        chk("drain_timeout", n < 60, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        int nreq;
        int guard;
        rst_n = 1'b0; clear = 1'b0; wt_addr_vld = 1'b0; wt_addr = '0; wt_addr_last = 1'b0;
        dma_wr_en = 1'b0; dma_wr_addr = '0; dma_wr_dat = '0; wt_dat_rdy = 1'b0;
        for (int k = 0; k < 64; k++) begin
            ram_mem[k] = '0;
            exp_mem[k] = '0;
        end
        rd1 = '0;
        #1;
        chk("rst_addr_rdy", wt_addr_rdy, 0);
        chk("rst_dat_vld", wt_dat_vld, 0);
        chk("rst_dat_last", wt_dat_last, 0);
        chk("rst_dat", wt_dat, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_idle", idle, 1);
        chk("rst_ram_en", ram_en, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: preload value=addr, stream 8 with full-rate sink
        for (int k = 0; k < 8; k++) dwr(k, DAT_W'(k));
        wt_dat_rdy = 1'b1; first_acc = -1; first_vld = -1; npop = 0;
        for (int k = 0; k < 8; k++) begin
            wt_addr_vld = 1'b1; wt_addr = ADDR_W'(k); wt_addr_last = (k == 3 || k == 7);
            tick();
            chk("t1_rdy", acc, 1);
        end
        drain();
        chk("t1_latency", first_vld - first_acc, 3);
        chk("t1_pops", npop, 8);

        // 2: sink stalled, credit limit of 4
        wt_dat_rdy = 1'b0; nacc = 0; npop = 0; i = 0;
        for (int c = 0; c < 8; c++) begin
            wt_addr_vld = 1'b1; wt_addr = ADDR_W'(i); wt_addr_last = (i == 3 || i == 7);
            tick();
            if (acc) i++;
        end
        chk("t2_accepts", nacc, 4);
        chk("t2_outstanding", outstanding, 4);
        chk("t2_addr_rdy", wt_addr_rdy, 0);
        wt_dat_rdy = 1'b1;
        while (i < 8) begin
            send(i, (i == 3 || i == 7));
            i++;
        end
        drain();
        chk("t2_pops", npop, 8);

        // 3: DMA writes interrupt a stream, then read back the written addresses
        send(1, 0);
        wt_addr_vld = 1'b1; wt_addr = 12'd2;
        dma_wr_en = 1'b1; dma_wr_addr = 12'd5; dma_wr_dat = DAT_W'('h5a5);
        #1;
        chk("t3_rdy_w0", wt_addr_rdy, 0);
        chk("t3_we_w0", ram_we, 1);
        chk("t3_en_w0", ram_en, 1);
        chk("t3_addr_w0", ram_addr, 5);
        chk("t3_wdat_w0", ram_wdat, 'h5a5);
        tick();
        dma_wr_addr = 12'd6; dma_wr_dat = DAT_W'('h6b6);
        #1;
        chk("t3_rdy_w1", wt_addr_rdy, 0);
        chk("t3_we_w1", ram_we, 1);
        chk("t3_addr_w1", ram_addr, 6);
        tick();
        dma_wr_en = 1'b0;
        wt_addr_vld = 1'b0;
        send(5, 0);
        send(6, 1);
        send(2, 0);
        drain();

        // 4: random traffic with occasional DMA writes
        for (int k = 0; k < 16; k++) dwr(k, {16{$urandom()}});
        nreq = 0; guard = 0;
        while (nreq < 1000 && guard < 20000) begin
            wt_dat_rdy = 1'($urandom_range(0, 1));
            dma_wr_en  = ($urandom_range(0, 15) == 0);
            dma_wr_addr = ADDR_W'($urandom_range(0, 15));
            dma_wr_dat  = {16{$urandom()}};
            if (!wt_addr_vld || acc) begin
                wt_addr_vld  = 1'($urandom_range(0, 1));
                wt_addr      = ADDR_W'($urandom_range(0, 15));
                wt_addr_last = 1'($urandom_range(0, 1));
            end
            tick();
            if (acc) nreq++;
            guard++;
        end
        dma_wr_en = 1'b0;
        drain();
        chk("t4_requests", nreq, 1000);

        // 5: clear with two words queued and two reads in flight
        wt_dat_rdy = 1'b0;
        send(0, 0); send(1, 0); send(2, 0); send(3, 1);
        chk("t5_pre_outstanding", outstanding, 4);
        chk("t5_pre_vld", wt_dat_vld, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        chk("t5_vld", wt_dat_vld, 0);
        chk("t5_outstanding", outstanding, 0);
        chk("t5_idle", idle, 1);
        wt_dat_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t5_stale", wt_dat_vld, 0);
        end
        send(2, 1);
        drain();

        // 6: asynchronous reset mid-stream
        wt_dat_rdy = 1'b1;
        wt_addr_vld = 1'b1; wt_addr = 12'd3; wt_addr_last = 1'b0;
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_addr_rdy", wt_addr_rdy, 0);
        chk("t6_vld", wt_dat_vld, 0);
        chk("t6_dat", wt_dat, 0);
        chk("t6_last", wt_dat_last, 0);
        chk("t6_outstanding", outstanding, 0);
        chk("t6_idle", idle, 1);
        q.delete();
        wt_addr_vld = 1'b0;
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        #1;
        chk("t6_idle_after", idle, 1);
        send(7, 0);
        send(4, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
